// File: rtl/eth_axis_loopback_responder_if.sv
// AXI-Stream bundle for the loopback responder: one instance per direction.
// A beat transfers on any rising clk edge where tvalid and tready are both 1;
// once tvalid is raised, tdata/tkeep/tlast/tuser hold until that transfer.
interface eth_axis_loopback_responder_if #(
    parameter int DATA_W = 128
);
    logic                tvalid;
    logic                tready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_axis_loopback_responder.sv
// Far-end Ethernet loopback: store-and-forward frame buffer that returns each
// good frame with DA/SA swapped; errored, disabled or overflowing frames are dropped.
module eth_axis_loopback_responder #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 64,
    parameter int MAC_SWAP   = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    eth_axis_loopback_responder_if.slave        s,
    eth_axis_loopback_responder_if.master       m,
    input  logic                                i_enable,
    output logic [31:0]                         o_pkt_cnt,
    output logic [31:0]                         o_drop_cnt,
    output logic [31:0]                         o_err_cnt,
    output logic [1:0]                          dbg_state
);

    localparam int KW = DATA_W / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = DATA_W + KW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DROP  = 2'd2
    } ing_state_t;

    ing_state_t state, state_nx;

    logic [MW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp, cp, rp;
    logic          full;
    logic          beat;
    logic          err_q, err_any;
    logic          wr_en, commit, rewind, inc_drop, inc_err;

    // MAC never back-pressures: ready simply follows reset.
    assign s.tready = rst_n;
    assign beat     = s.tvalid;
    assign full     = (wp - rp) == PW'(FIFO_DEPTH);
    assign err_any  = err_q | s.tuser;
    assign dbg_state = state;

    // ---------------- ingress FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (beat && !s.tlast) state_nx = (!i_enable || full) ? DROP : STORE;
            STORE: if (beat) begin
                if (s.tlast)   state_nx = IDLE;
                else if (full) state_nx = DROP;
            end
            DROP: if (beat && s.tlast) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        inc_drop = 1'b0;
        inc_err  = 1'b0;
        case (state)
            IDLE: if (beat) begin
                if (!i_enable || full) inc_drop = s.tlast;
                else if (s.tlast) begin
                    // Single-beat frame: nothing was written yet, so an error needs no rewind.
                    inc_err = s.tuser;
                    commit  = !s.tuser;
                end
                else wr_en = 1'b1;
            end
            STORE: if (beat) begin
                if (full) begin
                    rewind   = 1'b1;
                    inc_drop = s.tlast;
                end
                else if (s.tlast) begin
                    rewind  = err_any;
                    inc_err = err_any;
                    commit  = !err_any;
                end
                else wr_en = 1'b1;
            end
            DROP: inc_drop = beat && s.tlast;
            default: ;
        endcase
    end

    // ---------------- buffer write side ----------------
    always_ff @(posedge clk) begin
        if (wr_en || commit) mem[wp[AW-1:0]] <= {s.tdata, s.tkeep, s.tlast};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            cp    <= '0;
            err_q <= 1'b0;
        end else begin
            if (rewind) wp <= cp;
            else if (commit) begin
                wp <= wp + 1'b1;
                cp <= wp + 1'b1;
            end
            else if (wr_en) wp <= wp + 1'b1;
            if (beat) err_q <= (state == IDLE) ? s.tuser : err_any;
        end
    end

    // ---------------- egress: registered output stage ----------------
    logic [DATA_W-1:0] rd_data, ld_data;
    logic [KW-1:0]     rd_keep;
    logic              rd_last;
    logic              rd_first;
    logic              load;
    logic              m_valid, m_last;
    logic [DATA_W-1:0] m_data;
    logic [KW-1:0]     m_keep;

    assign {rd_data, rd_keep, rd_last} = mem[rp[AW-1:0]];
    // Only committed beats [rp, cp) are eligible; a partial frame is never seen here.
    assign load = (rp != cp) && (!m_valid || m.tready);

    always_comb begin
        ld_data = rd_data;
        if (MAC_SWAP != 0 && rd_first && (&rd_keep[11:0])) begin
            ld_data[47:0]  = rd_data[95:48];
            ld_data[95:48] = rd_data[47:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp       <= '0;
            rd_first <= 1'b1;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
            m_last   <= 1'b0;
        end else if (load) begin
            rp       <= rp + 1'b1;
            rd_first <= rd_last;
            m_valid  <= 1'b1;
            m_data   <= ld_data;
            m_keep   <= rd_keep;
            m_last   <= rd_last;
        end else if (m.tready) begin
            m_valid <= 1'b0;
        end
    end

    assign m.tvalid = m_valid;
    assign m.tdata  = m_data;
    assign m.tkeep  = m_keep;
    assign m.tlast  = m_last;
    assign m.tuser  = 1'b0;

    // ---------------- statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pkt_cnt  <= '0;
            o_drop_cnt <= '0;
            o_err_cnt  <= '0;
        end else begin
            if (m_valid && m.tready && m_last) o_pkt_cnt <= o_pkt_cnt + 1'b1;
            if (inc_drop) o_drop_cnt <= o_drop_cnt + 1'b1;
            if (inc_err)  o_err_cnt  <= o_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_axis_loopback_responder.sv
// Bench for eth_axis_loopback_responder: random frames driven into the TX side,
// returned beats scored against a byte-level model of swap/drop rules.
module tb_eth_axis_loopback_responder;

    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int EW = DW + KW + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [31:0] o_pkt_cnt, o_drop_cnt, o_err_cnt;
    logic [1:0]  dbg_state;

    eth_axis_loopback_responder_if #(.DATA_W(DW)) s_if ();
    eth_axis_loopback_responder_if #(.DATA_W(DW)) m_if ();

    eth_axis_loopback_responder #(.DATA_W(DW), .FIFO_DEPTH(64), .MAC_SWAP(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (s_if),
        .m          (m_if),
        .i_enable   (i_enable),
        .o_pkt_cnt  (o_pkt_cnt),
        .o_drop_cnt (o_drop_cnt),
        .o_err_cnt  (o_err_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q [$];
    logic [31:0]   exp_pkt, exp_drop, exp_err;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            rdy_mode = 1;   // 0: always ready, 1: never ready, 2: random
    logic [7:0]    fbytes [0:1199];

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- egress ready driver ----------------
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'b0;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- egress monitor ----------------
    always @(negedge clk) begin
        if (rst_n && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", EW'(exp_q.size()), EW'(1));
            end else begin
                check("beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, exp_q.pop_front());
                check("tuser", EW'(m_if.tuser), EW'(0));
            end
        end
    end

    // ---------------- reference model ----------------
    // A returned frame is the sent byte string with bytes 0-5 and 6-11 exchanged
    // whenever it holds at least 12 bytes, cut into 16-byte beats.
    task automatic model_push(input int len);
        logic [7:0]    e [0:1199];
        logic [7:0]    t;
        logic [EW-1:0] w;
        int            nb;
        for (int i = 0; i < len; i++) e[i] = fbytes[i];
        if (len >= 12) begin
            for (int i = 0; i < 6; i++) begin
                t        = e[i];
                e[i]     = e[i + 6];
                e[i + 6] = t;
            end
        end
        nb = (len + KW - 1) / KW;
        for (int b = 0; b < nb; b++) begin
            w = '0;
            for (int k = 0; k < KW; k++) begin
                if (b * KW + k < len) begin
                    w[KW + 1 + k * 8 +: 8] = e[b * KW + k];
                    w[1 + k]               = 1'b1;
                end
            end
            w[0] = (b == nb - 1);
            exp_q.push_back(w);
        end
    endtask

    // ---------------- ingress driver ----------------
    // Called at posedge+1; drives one beat per cycle and returns at posedge+1
    // right after the tlast beat is taken.
    task automatic send_frame(input int len, input bit en0, input int en_raise_beat,
                              input int err_beat, input bit exp_ovf, input bit fixed_mac);
        int nb;
        nb = (len + KW - 1) / KW;
        for (int i = 0; i < len; i++) fbytes[i] = 8'($urandom_range(0, 255));
        if (fixed_mac) begin
            fbytes[0] = 8'h00; fbytes[1]  = 8'h11; fbytes[2]  = 8'h22;
            fbytes[3] = 8'h33; fbytes[4]  = 8'h44; fbytes[5]  = 8'h55;
            fbytes[6] = 8'h66; fbytes[7]  = 8'h77; fbytes[8]  = 8'h88;
            fbytes[9] = 8'h99; fbytes[10] = 8'hAA; fbytes[11] = 8'hBB;
        end
        if (!en0 || exp_ovf) exp_drop++;
        else if (err_beat >= 0) exp_err++;
        else begin
            model_push(len);
            exp_pkt++;
        end
        i_enable = en0;
        for (int b = 0; b < nb; b++) begin
            if (b == en_raise_beat) i_enable = 1'b1;
            s_if.tdata = '0;
            s_if.tkeep = '0;
            for (int k = 0; k < KW; k++) begin
                if (b * KW + k < len) begin
                    s_if.tdata[k * 8 +: 8] = fbytes[b * KW + k];
                    s_if.tkeep[k]          = 1'b1;
                end
            end
            s_if.tlast  = (b == nb - 1);
            s_if.tuser  = (b == err_beat);
            s_if.tvalid = 1'b1;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt"},  EW'(o_pkt_cnt),  EW'(exp_pkt));
        check({tag, "_drop"}, EW'(o_drop_cnt), EW'(exp_drop));
        check({tag, "_err"},  EW'(o_err_cnt),  EW'(exp_err));
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_drain"}, EW'(exp_q.size()), EW'(0));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle"}, EW'(m_if.tvalid), EW'(0));
        check_counters(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, EW'(s_if.tready), EW'(0));
        check({tag, "_m_tvalid"}, EW'(m_if.tvalid), EW'(0));
        check({tag, "_m_tdata"},  EW'(m_if.tdata),  EW'(0));
        check({tag, "_m_tkeep"},  EW'(m_if.tkeep),  EW'(0));
        check({tag, "_m_tlast"},  EW'(m_if.tlast),  EW'(0));
        check({tag, "_m_tuser"},  EW'(m_if.tuser),  EW'(0));
        check({tag, "_pkt"},      EW'(o_pkt_cnt),   EW'(0));
        check({tag, "_drop"},     EW'(o_drop_cnt),  EW'(0));
        check({tag, "_err"},      EW'(o_err_cnt),   EW'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        exp_pkt = '0; exp_drop = '0; exp_err = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
        s_if.tlast = 1'b0; s_if.tuser = 1'b0; i_enable = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Single 64-byte frame: latency and DA/SA swap
        send_frame(64, 1, -1, -1, 0, 1);
        check("lat_n1", EW'(m_if.tvalid), EW'(0));
        @(posedge clk);
        #1;
        check("lat_n2", EW'(m_if.tvalid), EW'(1));
        check("da_swap", EW'(m_if.tdata[47:0]), EW'(48'hBBAA99887766));
        check("sa_swap", EW'(m_if.tdata[95:48]), EW'(48'h554433221100));
        wait_drain("single");

        // Errored frame then a good 2-beat frame
        send_frame(64, 1, -1, 3, 0, 0);
        send_frame(32, 1, -1, -1, 0, 0);
        wait_drain("err");

        // Overflow with egress stalled, then a normal frame once released
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send_frame(70 * KW, 1, -1, -1, 1, 0);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_no_egress", EW'(m_if.tvalid), EW'(0));
        check("ovf_drop", EW'(o_drop_cnt), EW'(exp_drop));
        rdy_mode = 0;
        send_frame(8 * KW, 1, -1, -1, 0, 0);
        wait_drain("ovf_after");

        // Back-to-back single-beat frames with random egress ready
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) send_frame($urandom_range(1, KW), 1, -1, -1, 0, 0);
        wait_drain("b2b");

        // Enable low at first beat, raised mid-frame; short frame passes unswapped
        rdy_mode = 0;
        send_frame(48, 0, 1, -1, 0, 0);
        send_frame(8, 1, -1, -1, 0, 0);
        wait_drain("enable");

        // Random mix of good, errored and disabled frames
        rdy_mode = 2;
        for (int i = 0; i < 12; i++) begin
            int len;
            int eb;
            len = $urandom_range(1, 64);
            eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (len + KW - 1) / KW - 1) : -1;
            send_frame(len, $urandom_range(0, 3) != 0, -1, eb, 0, 0);
        end
        wait_drain("mix");

        // Reset while one frame is held at egress and another is arriving
        rdy_mode = 1;
        send_frame(32, 1, -1, -1, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        i_enable    = 1'b1;
        s_if.tdata  = {4{32'hDEADBEEF}};
        s_if.tkeep  = '1;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        s_if.tvalid = 1'b0;
        exp_q.delete();
        exp_pkt = '0; exp_drop = '0; exp_err = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_frame(64, 1, -1, -1, 0, 1);
        wait_drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
